// File: rtl/if_fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int STALL_W = 6;
    localparam int INST_W  = 32;

    typedef enum logic {
        IF_IDLE   = 1'b0,
        IF_REFILL = 1'b1
    } if_state_e;

    // Little-endian byte assembly: lane 0 lands in bits [7:0].
    function automatic logic [INST_W-1:0] set_lane(input logic [INST_W-1:0] word,
                                                   input logic [1:0]        lane,
                                                   input logic [7:0]        data);
        logic [INST_W-1:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            default: res[31:24] = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Byte-serial refill bus between the fetch stage (master) and the memory controller (slave).
interface if_fetch_unit_if #(parameter int ADDR_W = 32);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [7:0]        mem_byte_i;

    modport master (output mem_req_o, output mem_addr_o, input mem_ack_i, input mem_byte_i);
    modport slave  (input mem_req_o, input mem_addr_o, output mem_ack_i, output mem_byte_i);
endinterface

// File: rtl/if_fetch_unit_icache_dm.sv
// Direct-mapped one-word-per-line I-cache: combinational lookup, synchronous write port.
module icache_dm #(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-3:0] rd_waddr_i,
    output logic              hit_o,
    output logic [31:0]       rd_data_o,
    input  logic              we_i,
    input  logic [ADDR_W-3:0] wr_waddr_i,
    input  logic [31:0]       wr_data_i
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    assign rd_idx    = rd_waddr_i[IDX_W-1:0];
    assign wr_idx    = wr_waddr_i[IDX_W-1:0];
    assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_waddr_i[ADDR_W-3:IDX_W]);
    assign rd_data_o = data_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone gate a hit.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx]  <= wr_waddr_i[ADDR_W-3:IDX_W];
            data_q[wr_idx] <= wr_data_i;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: I-cache lookup, byte-serial refill FSM and the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_state,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               jmp_i,
    if_fetch_unit_if.master    mem,
    output logic               stall_req_o,
    output logic               id_valid_o,
    output logic [INST_W-1:0]  id_inst_o,
    output logic [ADDR_W-1:0]  id_pc_o,
    output logic               id_jmp_o
);
    if_state_e          state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  lpc_q, lpc_d;
    logic               ljmp_q, ljmp_d;
    logic [INST_W-1:0]  word_q, word_d;
    logic               pend_q, pend_d;
    logic               id_valid_q, id_valid_d;
    logic [INST_W-1:0]  id_inst_q, id_inst_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
    logic               id_jmp_q, id_jmp_d;

    logic               hold, hit, last_ack, stall_req, mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INST_W-1:0]  cache_word, asm_word;
    logic               unused_stall;

    assign hold         = stall_state[1];
    assign unused_stall = ^{stall_state[STALL_W-1:2], stall_state[0]};
    assign asm_word     = set_lane(word_q, cnt_q, mem.mem_byte_i);
    assign last_ack     = (state_q == IF_REFILL) && mem.mem_ack_i && (cnt_q == 2'd3);

    icache_dm #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) u_icache (
        .clk        (clk),
        .rst        (rst),
        .rd_waddr_i (pc_i[ADDR_W-1:2]),
        .hit_o      (hit),
        .rd_data_o  (cache_word),
        .we_i       (last_ack),
        .wr_waddr_i (lpc_q[ADDR_W-1:2]),
        .wr_data_i  (asm_word)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lpc_d      = lpc_q;
        ljmp_d     = ljmp_q;
        word_d     = word_q;
        pend_d     = pend_q;
        id_valid_d = hold ? id_valid_q : 1'b0;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        id_jmp_d   = id_jmp_q;
        stall_req  = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        case (state_q)
            IF_IDLE: begin
                if (pend_q) begin
                    // A refill finished under stall; hand it over once IF/ID is free.
                    if (!flush_i && !hold) begin
                        id_valid_d = 1'b1;
                        id_inst_d  = word_q;
                        id_pc_d    = lpc_q;
                        id_jmp_d   = ljmp_q;
                        pend_d     = 1'b0;
                    end
                end else if (!hit) begin
                    stall_req = !flush_i;
                    if (!flush_i) begin
                        lpc_d   = pc_i;
                        ljmp_d  = jmp_i;
                        cnt_d   = 2'd0;
                        word_d  = '0;
                        state_d = IF_REFILL;
                    end
                end else if (!flush_i && !hold) begin
                    id_valid_d = 1'b1;
                    id_inst_d  = cache_word;
                    id_pc_d    = pc_i;
                    id_jmp_d   = jmp_i;
                end
            end
            IF_REFILL: begin
                mem_req   = 1'b1;
                mem_addr  = {lpc_q[ADDR_W-1:2], cnt_q};
                stall_req = 1'b1;
                if (!flush_i && mem.mem_ack_i) begin
                    word_d = asm_word;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = IF_IDLE;
                        if (hold) begin
                            pend_d = 1'b1;
                        end else begin
                            id_valid_d = 1'b1;
                            id_inst_d  = asm_word;
                            id_pc_d    = lpc_q;
                            id_jmp_d   = ljmp_q;
                        end
                    end
                end
            end
            default: state_d = IF_IDLE;
        endcase
        // Mispredict beats stall and hit; a coincident 4th ack still fills the cache.
        if (flush_i) begin
            state_d    = IF_IDLE;
            cnt_d      = 2'd0;
            pend_d     = 1'b0;
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IF_IDLE;
            cnt_q      <= 2'd0;
            pend_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            id_pc_q    <= '0;
            id_jmp_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_jmp_q   <= id_jmp_d;
        end
    end

    always_ff @(posedge clk) begin
        lpc_q  <= lpc_d;
        ljmp_q <= ljmp_d;
        word_q <= word_d;
    end

    assign stall_req_o    = stall_req && !rst;
    assign mem.mem_req_o  = mem_req;
    assign mem.mem_addr_o = mem_addr;
    assign id_valid_o     = id_valid_q;
    assign id_inst_o      = id_inst_q;
    assign id_pc_o        = id_pc_q;
    assign id_jmp_o       = id_jmp_q;

endmodule
